// File: rtl/icache_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// icache_fetch_ctrl_pkg
//   Shared constants and types for the I-cache fetch controller:
//   default geometry, the block-address width helper and the FSM state type.
//   No ports; imported by the interface, the controller and its word mux.
// -----------------------------------------------------------------------------
package icache_fetch_ctrl_pkg;

  // Default geometry: 32-bit PC, 32-bit instructions, 4-word (16-byte) blocks.
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_WORD_W      = 32;
  localparam int DEF_BLOCK_WORDS = 4;
  localparam int DEF_CNT_W       = 32;

  // Block address = PC with the byte-within-block offset stripped ([TAG,INDEX]).
  function automatic int blk_addr_w(input int addr_w, input int word_w,
                                    input int block_words);
    return addr_w - $clog2(block_words * word_w / 8);
  endfunction

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,  // normal lookup, zero-latency hit path
    ST_MISS = 2'd1,  // waiting for the block from main memory
    ST_FILL = 2'd2   // writing the returned block into the array
  } state_t;

endpackage

// File: rtl/icache_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// icache_fetch_ctrl_if
//   Bundles the three buses around the fetch controller:
//     CPU IF stage : cpu_req, cpu_addr, cpu_instr, cpu_instr_valid, cpu_stall
//     I-cache array: sram_ren, sram_wen, sram_block_addr, sram_data_in,
//                    sram_hit, sram_data_out
//     Main memory  : mem_req, mem_block_addr, mem_rvalid, mem_rdata
//   modport master : the controller side
//   modport slave  : the environment side (CPU, array and memory)
// -----------------------------------------------------------------------------
interface icache_fetch_ctrl_if
  import icache_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
);

  localparam int BLK_ADDR_W = blk_addr_w(ADDR_W, WORD_W, BLOCK_WORDS);
  localparam int BLOCK_W    = BLOCK_WORDS * WORD_W;

  // CPU fetch port
  logic                  cpu_req;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [WORD_W-1:0]     cpu_instr;
  logic                  cpu_instr_valid;
  logic                  cpu_stall;

  // I-cache array port
  logic                  sram_ren;
  logic                  sram_wen;
  logic [BLK_ADDR_W-1:0] sram_block_addr;
  logic [BLOCK_W-1:0]    sram_data_in;
  logic                  sram_hit;
  logic [BLOCK_W-1:0]    sram_data_out;

  // Main-memory block read port
  logic                  mem_req;
  logic [BLK_ADDR_W-1:0] mem_block_addr;
  logic                  mem_rvalid;
  logic [BLOCK_W-1:0]    mem_rdata;

  modport master (
    input  cpu_req, cpu_addr, sram_hit, sram_data_out, mem_rvalid, mem_rdata,
    output cpu_instr, cpu_instr_valid, cpu_stall,
           sram_ren, sram_wen, sram_block_addr, sram_data_in,
           mem_req, mem_block_addr
  );

  modport slave (
    output cpu_req, cpu_addr, sram_hit, sram_data_out, mem_rvalid, mem_rdata,
    input  cpu_instr, cpu_instr_valid, cpu_stall,
           sram_ren, sram_wen, sram_block_addr, sram_data_in,
           mem_req, mem_block_addr
  );

endinterface

// File: rtl/icache_fetch_ctrl_word_sel.sv
// -----------------------------------------------------------------------------
// icache_fetch_ctrl_word_sel
//   Combinational block-to-word mux: picks word 'off' out of a cache block,
//   word 0 sitting at the least-significant bits.
//   Ports:
//     block  in   BLOCK_WORDS*WORD_W  cache block
//     off    in   log2(BLOCK_WORDS)   word offset within the block
//     word   out  WORD_W              selected word
// -----------------------------------------------------------------------------
module icache_fetch_ctrl_word_sel #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic [BLOCK_WORDS*WORD_W-1:0]  block,
  input  logic [$clog2(BLOCK_WORDS)-1:0] off,
  output logic [WORD_W-1:0]              word
);

  assign word = block[off*WORD_W +: WORD_W];

endmodule

// File: rtl/icache_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// icache_fetch_ctrl
//   Fetch-side controller between the CPU IF stage and the I-cache array.
//   Hits return the addressed word in the same cycle; a miss stalls the CPU,
//   reads the whole block from main memory, writes it into the array and then
//   lets the lookup run again. Saturating hit/miss counters are kept here.
//   Ports:
//     clk       in   1      clock
//     rst       in   1      asynchronous, active-low reset
//     bus       master     CPU / array / memory buses (icache_fetch_ctrl_if)
//     hit_cnt   out  CNT_W  lookups that hit (saturating)
//     miss_cnt  out  CNT_W  misses taken (saturating)
// -----------------------------------------------------------------------------
module icache_fetch_ctrl
  import icache_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  icache_fetch_ctrl_if.master bus,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  localparam int BLK_ADDR_W = blk_addr_w(ADDR_W, WORD_W, BLOCK_WORDS);
  localparam int BLOCK_W    = BLOCK_WORDS * WORD_W;
  localparam int WORD_LSB   = $clog2(WORD_W / 8);          // byte-in-word bits
  localparam int OFF_W      = $clog2(BLOCK_WORDS);         // word-in-block bits
  localparam int BLK_LSB    = WORD_LSB + OFF_W;            // first block-address bit

  state_t                state_q, state_d;
  logic [BLK_ADDR_W-1:0] miss_addr_q;
  logic [BLOCK_W-1:0]    fill_buf_q;
  logic [CNT_W-1:0]      hit_cnt_q, miss_cnt_q;

  logic [BLK_ADDR_W-1:0] cpu_blk;
  logic [OFF_W-1:0]      cpu_off;
  logic [WORD_W-1:0]     sel_word;
  logic                  run_hit, run_miss;
  logic                  unused_addr_bits;

  assign cpu_blk  = bus.cpu_addr[ADDR_W-1:BLK_LSB];
  assign cpu_off  = bus.cpu_addr[BLK_LSB-1:WORD_LSB];
  // Instructions are word aligned, the byte-in-word bits carry no information.
  assign unused_addr_bits = ^bus.cpu_addr[WORD_LSB-1:0];

  assign run_hit  = (state_q == ST_RUN) && bus.cpu_req &&  bus.sram_hit;
  assign run_miss = (state_q == ST_RUN) && bus.cpu_req && !bus.sram_hit;

  icache_fetch_ctrl_word_sel #(
    .WORD_W      (WORD_W),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_word_sel (
    .block (bus.sram_data_out),
    .off   (cpu_off),
    .word  (sel_word)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (run_miss)       state_d = ST_MISS;
      ST_MISS: if (bus.mem_rvalid) state_d = ST_FILL;  // rvalid only counts here
      ST_FILL:                     state_d = ST_RUN;
      default:                     state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.cpu_instr       = '0;
    bus.cpu_instr_valid = 1'b0;
    bus.cpu_stall       = 1'b0;
    bus.sram_ren        = 1'b0;
    bus.sram_wen        = 1'b0;
    bus.sram_block_addr = '0;
    if (!rst) begin
      // Hold the PC of a pending request until the controller leaves reset.
      bus.cpu_stall = bus.cpu_req;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          bus.sram_ren        = bus.cpu_req;
          bus.sram_block_addr = cpu_blk;
          bus.cpu_stall       = run_miss;
          if (run_hit) begin
            bus.cpu_instr_valid = 1'b1;
            bus.cpu_instr       = sel_word;
          end
        end
        ST_MISS: begin
          bus.cpu_stall       = 1'b1;
          bus.sram_block_addr = miss_addr_q;
        end
        ST_FILL: begin
          // ren stays low here: the array would otherwise let ren win over wen.
          bus.sram_wen        = 1'b1;
          bus.cpu_stall       = 1'b1;
          bus.sram_block_addr = miss_addr_q;
        end
        default: ;
      endcase
    end
  end

  // Request is a level taken straight from the state, so an asynchronous
  // reset mid-miss drops it immediately.
  assign bus.mem_req        = (state_q == ST_MISS);
  assign bus.mem_block_addr = miss_addr_q;
  assign bus.sram_data_in   = fill_buf_q;

  // ---------------------------------------------------------------------------
  // Miss address and fill buffer
  // ---------------------------------------------------------------------------
  // NOTE: fill_buf is an ordinary register bank rather than an SRAM macro, so
  // it can take the asynchronous clear like the rest of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_addr_q <= '0;
      fill_buf_q  <= '0;
    end else begin
      // The fill targets the PC that missed, even if the CPU moves on meanwhile.
      if (run_miss)                                  miss_addr_q <= cpu_blk;
      if ((state_q == ST_MISS) && bus.mem_rvalid)    fill_buf_q  <= bus.mem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters. The re-lookup after every refill hits and
  // is counted as a hit on purpose.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (run_hit  && !(&hit_cnt_q))  hit_cnt_q  <= hit_cnt_q  + CNT_W'(1);
      if (run_miss && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_fetch_ctrl
//   Self-checking bench for icache_fetch_ctrl. Provides a behavioural I-cache
//   array (never evicts), a main-memory responder with programmable latency and
//   a reference memory image; expected instructions are the memory word at the
//   requested byte address.
// -----------------------------------------------------------------------------
module tb_icache_fetch_ctrl;
  import icache_fetch_ctrl_pkg::*;

  localparam int ADDR_W      = DEF_ADDR_W;
  localparam int WORD_W      = DEF_WORD_W;
  localparam int BLOCK_WORDS = DEF_BLOCK_WORDS;
  localparam int CNT_W       = DEF_CNT_W;
  localparam int BLK_ADDR_W  = blk_addr_w(ADDR_W, WORD_W, BLOCK_WORDS);
  localparam int BLOCK_W     = BLOCK_WORDS * WORD_W;
  localparam int SRAM_DEPTH  = 256;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  icache_fetch_ctrl_if bus ();
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  icache_fetch_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference memory image ----------------
  function automatic logic [WORD_W-1:0] mem_word(input logic [ADDR_W-1:0] widx);
    return (widx * 32'h9E37_79B1) ^ (widx << 7) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [BLOCK_W-1:0] mem_block(input logic [BLK_ADDR_W-1:0] blk);
    logic [BLOCK_W-1:0] b;
    b = '0;
    for (int i = 0; i < BLOCK_WORDS; i++)
      b[i*WORD_W +: WORD_W] = mem_word(ADDR_W'(blk) * ADDR_W'(BLOCK_WORDS) + ADDR_W'(i));
    return b;
  endfunction

  function automatic logic [BLK_ADDR_W-1:0] blk_of(input logic [ADDR_W-1:0] pc);
    return BLK_ADDR_W'(pc / (BLOCK_WORDS * WORD_W / 8));
  endfunction

  // ---------------- behavioural I-cache array ----------------
  logic [SRAM_DEPTH-1:0] sram_vld = '0;
  logic [BLOCK_W-1:0]    sram_mem [SRAM_DEPTH];
  logic                  sram_in_range;

  assign sram_in_range = bus.sram_block_addr < BLK_ADDR_W'(SRAM_DEPTH);

  always_comb begin
    bus.sram_hit      = 1'b0;
    bus.sram_data_out = '0;
    if (bus.sram_ren && sram_in_range && sram_vld[bus.sram_block_addr[7:0]]) begin
      bus.sram_hit      = 1'b1;
      bus.sram_data_out = sram_mem[bus.sram_block_addr[7:0]];
    end
  end

  always @(posedge clk) begin
    if (bus.sram_wen && !bus.sram_ren && sram_in_range) begin
      sram_vld[bus.sram_block_addr[7:0]] <= 1'b1;
      sram_mem[bus.sram_block_addr[7:0]] <= bus.sram_data_in;
    end
  end

  // ---------------- main-memory responder ----------------
  logic               auto_rvalid = 1'b0;
  logic [BLOCK_W-1:0] auto_rdata  = '0;
  logic               man_rvalid  = 1'b0;
  logic [BLOCK_W-1:0] man_rdata   = '0;
  bit                 mem_auto    = 1'b1;
  int                 mem_lat     = 3;
  int                 mem_busy    = 0;

  assign bus.mem_rvalid = auto_rvalid | man_rvalid;
  assign bus.mem_rdata  = auto_rvalid ? auto_rdata : man_rdata;

  // Pulses mem_rvalid in the mem_lat-th cycle of a request.
  initial begin
    forever begin
      @(negedge clk);
      auto_rvalid = 1'b0;
      if (mem_auto && bus.mem_req) begin
        mem_busy++;
        if (mem_busy >= mem_lat) begin
          auto_rvalid = 1'b1;
          auto_rdata  = mem_block(bus.mem_block_addr);
          mem_busy    = 0;
        end
      end else begin
        mem_busy = 0;
      end
    end
  end

  // Blocks the bench believes are in the array.
  bit [SRAM_DEPTH-1:0] exp_cached = '0;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; bus.cpu_req = 1'b0; bus.cpu_addr = '0;
    repeat (2) @(negedge clk);
    #2;
    n_tests++;
    if ({bus.cpu_instr_valid, bus.cpu_stall, bus.sram_ren, bus.sram_wen, bus.mem_req} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000",
        {bus.cpu_instr_valid, bus.cpu_stall, bus.sram_ren, bus.sram_wen, bus.mem_req});
    end
    n_tests++;
    if ({bus.cpu_instr, bus.sram_block_addr, bus.mem_block_addr} !== '0) begin
      n_fail++; $display("FAIL reset_addr_instr: got %h/%h/%h want 0",
        bus.cpu_instr, bus.sram_block_addr, bus.mem_block_addr);
    end
    n_tests++;
    if (bus.sram_data_in !== '0) begin
      n_fail++; $display("FAIL reset_fill_buf: got %h want 0", bus.sram_data_in);
    end
    n_tests++;
    if ({hit_cnt, miss_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", hit_cnt, miss_cnt);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    int cyc;
    @(negedge clk); mem_lat = 3; bus.cpu_addr = 32'h100; bus.cpu_req = 1'b1; #2;
    n_tests++;
    if ({bus.cpu_stall, bus.sram_ren, bus.mem_req, bus.cpu_instr_valid} !== 4'b1100) begin
      n_fail++; $display("FAIL t1_detect: got stall/ren/mreq/valid=%b want 1100",
        {bus.cpu_stall, bus.sram_ren, bus.mem_req, bus.cpu_instr_valid});
    end
    @(negedge clk); #2;
    n_tests++;
    if ({bus.mem_req, bus.cpu_stall, bus.sram_ren} !== 3'b110 || bus.mem_block_addr !== BLK_ADDR_W'('h10)) begin
      n_fail++; $display("FAIL t1_mem_req: got req/stall/ren=%b addr=%h want 110 addr=10",
        {bus.mem_req, bus.cpu_stall, bus.sram_ren}, bus.mem_block_addr);
    end
    cyc = 1;
    while (!bus.sram_wen && cyc < 20) begin @(negedge clk); #2; cyc++; end
    n_tests++;
    if (cyc !== 4) begin
      n_fail++; $display("FAIL t1_fill_cycle: got %0d want 4", cyc);
    end
    n_tests++;
    if (bus.sram_block_addr !== BLK_ADDR_W'('h10) || bus.sram_data_in !== mem_block(BLK_ADDR_W'('h10))
        || bus.sram_ren !== 1'b0 || bus.cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL t1_fill: got addr=%h ren=%b stall=%b data=%h want addr=10 ren=0 stall=1",
        bus.sram_block_addr, bus.sram_ren, bus.cpu_stall, bus.sram_data_in);
    end
    exp_cached['h10] = 1'b1;
    @(negedge clk); #2;
    n_tests++;
    if ({bus.cpu_instr_valid, bus.cpu_stall} !== 2'b10 || bus.cpu_instr !== mem_word(32'h100 >> 2)) begin
      n_fail++; $display("FAIL t1_relookup: got valid/stall=%b instr=%h want 10 instr=%h",
        {bus.cpu_instr_valid, bus.cpu_stall}, bus.cpu_instr, mem_word(32'h100 >> 2));
    end
    @(negedge clk); bus.cpu_req = 1'b0; #2;
    n_tests++;
    if (hit_cnt !== CNT_W'(1) || miss_cnt !== CNT_W'(1)) begin
      n_fail++; $display("FAIL t1_counters: got hit=%0d miss=%0d want 1/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] pcs [3];
    pcs[0] = 32'h104; pcs[1] = 32'h108; pcs[2] = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.cpu_addr = pcs[i]; bus.cpu_req = 1'b1; #2;
      n_tests++;
      if ({bus.cpu_instr_valid, bus.cpu_stall} !== 2'b10 || bus.cpu_instr !== mem_word(pcs[i] >> 2)) begin
        n_fail++; $display("FAIL t2_word%0d: got valid/stall=%b instr=%h want 10 instr=%h",
          i + 1, {bus.cpu_instr_valid, bus.cpu_stall}, bus.cpu_instr, mem_word(pcs[i] >> 2));
      end
    end
    @(negedge clk); bus.cpu_req = 1'b0; #2;
    n_tests++;
    if (hit_cnt !== CNT_W'(4) || miss_cnt !== CNT_W'(1)) begin
      n_fail++; $display("FAIL t2_counters: got hit=%0d miss=%0d want 4/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_pc_change();
    int cyc;
    @(negedge clk); mem_lat = 2; bus.cpu_addr = 32'h200; bus.cpu_req = 1'b1; #2;
    n_tests++;
    if (bus.cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL t3_detect: got stall=%b want 1", bus.cpu_stall);
    end
    @(negedge clk); bus.cpu_addr = 32'h100; #2;
    n_tests++;
    if (bus.mem_req !== 1'b1 || bus.mem_block_addr !== BLK_ADDR_W'('h20)) begin
      n_fail++; $display("FAIL t3_mem_req: got req=%b addr=%h want 1 addr=20", bus.mem_req, bus.mem_block_addr);
    end
    cyc = 1;
    while (!bus.sram_wen && cyc < 20) begin @(negedge clk); #2; cyc++; end
    n_tests++;
    if (bus.sram_wen !== 1'b1 || bus.sram_block_addr !== BLK_ADDR_W'('h20)
        || bus.sram_data_in !== mem_block(BLK_ADDR_W'('h20))) begin
      n_fail++; $display("FAIL t3_fill: got wen=%b addr=%h data=%h want wen=1 addr=20",
        bus.sram_wen, bus.sram_block_addr, bus.sram_data_in);
    end
    exp_cached['h20] = 1'b1;
    @(negedge clk); #2;
    n_tests++;
    if ({bus.cpu_instr_valid, bus.cpu_stall} !== 2'b10 || bus.cpu_instr !== mem_word(32'h100 >> 2)) begin
      n_fail++; $display("FAIL t3_new_pc_hit: got valid/stall=%b instr=%h want 10 instr=%h",
        {bus.cpu_instr_valid, bus.cpu_stall}, bus.cpu_instr, mem_word(32'h100 >> 2));
    end
    @(negedge clk); bus.cpu_addr = 32'h200; #2;
    n_tests++;
    if ({bus.cpu_instr_valid, bus.cpu_stall} !== 2'b10 || bus.cpu_instr !== mem_word(32'h200 >> 2)) begin
      n_fail++; $display("FAIL t3_filled_block: got valid/stall=%b instr=%h want 10 instr=%h",
        {bus.cpu_instr_valid, bus.cpu_stall}, bus.cpu_instr, mem_word(32'h200 >> 2));
    end
    @(negedge clk); bus.cpu_req = 1'b0; #2;
    n_tests++;
    if (hit_cnt !== CNT_W'(6) || miss_cnt !== CNT_W'(2)) begin
      n_fail++; $display("FAIL t3_counters: got hit=%0d miss=%0d want 6/2", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_reset_mid_miss();
    mem_auto = 1'b0;
    @(negedge clk); bus.cpu_addr = 32'h300; bus.cpu_req = 1'b1;
    @(negedge clk); #2;
    n_tests++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL t4_in_miss: got mem_req=%b want 1", bus.mem_req);
    end
    #1 rst = 1'b0; bus.cpu_req = 1'b0;
    #1;
    n_tests++;
    if (bus.mem_req !== 1'b0 || dut.state_q !== ST_RUN) begin
      n_fail++; $display("FAIL t4_async_drop: got mem_req=%b state=%0d want 0/RUN", bus.mem_req, dut.state_q);
    end
    n_tests++;
    if ({hit_cnt, miss_cnt} !== '0) begin
      n_fail++; $display("FAIL t4_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt);
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      man_rvalid = (i == 1);
      man_rdata  = mem_block(BLK_ADDR_W'('h30)) ^ {BLOCK_WORDS{$urandom()}};
      #2;
      n_tests++;
      if ({bus.sram_wen, bus.mem_req, bus.cpu_stall, bus.cpu_instr_valid} !== 4'b0) begin
        n_fail++; $display("FAIL t4_late_rvalid_c%0d: got wen/mreq/stall/valid=%b want 0000",
          i, {bus.sram_wen, bus.mem_req, bus.cpu_stall, bus.cpu_instr_valid});
      end
    end
    man_rvalid = 1'b0;
    n_tests++;
    if (sram_vld['h30] !== 1'b0) begin
      n_fail++; $display("FAIL t4_no_fill: got block 0x30 valid=%b want 0", sram_vld['h30]);
    end
    mem_auto = 1'b1;
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0]     pc;
    logic [BLK_ADDR_W-1:0] blk;
    int gap, cyc, exp_cyc;
    int exp_hits   = 0;
    int exp_misses = 0;
    for (int n = 0; n < 60; n++) begin
      pc  = ADDR_W'($urandom_range(0, 255)) << 2;
      blk = blk_of(pc);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); bus.cpu_req = 1'b0; bus.cpu_addr = ADDR_W'($urandom()); #2;
        n_tests++;
        if ({bus.cpu_instr_valid, bus.cpu_stall, bus.cpu_instr} !== '0) begin
          n_fail++; $display("FAIL t6_idle_%0d: got valid=%b stall=%b instr=%h want 0",
            n, bus.cpu_instr_valid, bus.cpu_stall, bus.cpu_instr);
        end
      end
      @(negedge clk); mem_lat = $urandom_range(1, 4); bus.cpu_addr = pc; bus.cpu_req = 1'b1; #2;
      exp_cyc = exp_cached[blk[7:0]] ? 1 : mem_lat + 3;
      cyc = 1;
      while (!bus.cpu_instr_valid && cyc < 30) begin
        n_tests++;
        if ((bus.sram_ren && bus.sram_wen) || bus.cpu_instr !== '0 || bus.cpu_stall !== 1'b1) begin
          n_fail++; $display("FAIL t6_stall_cycle_%0d: got ren=%b wen=%b stall=%b instr=%h want no ren&wen, stall=1, instr=0",
            n, bus.sram_ren, bus.sram_wen, bus.cpu_stall, bus.cpu_instr);
        end
        @(negedge clk); #2; cyc++;
      end
      n_tests++;
      if (cyc !== exp_cyc) begin
        n_fail++; $display("FAIL t6_latency_%0d: pc=%h got %0d cycles want %0d", n, pc, cyc, exp_cyc);
      end
      n_tests++;
      if (bus.cpu_instr !== mem_word(pc >> 2)) begin
        n_fail++; $display("FAIL t6_instr_%0d: pc=%h got %h want %h", n, pc, bus.cpu_instr, mem_word(pc >> 2));
      end
      if (!exp_cached[blk[7:0]]) exp_misses++;
      exp_hits++;
      exp_cached[blk[7:0]] = 1'b1;
    end
    @(negedge clk); bus.cpu_req = 1'b0; #2;
    n_tests++;
    if (hit_cnt !== CNT_W'(exp_hits) || miss_cnt !== CNT_W'(exp_misses)) begin
      n_fail++; $display("FAIL t6_counters: got hit=%0d miss=%0d want %0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
  endtask

  task automatic test_hit_saturation();
    logic [CNT_W-1:0] start;
    logic [63:0]      e;
    start = CNT_MAX - CNT_W'(2);
    @(negedge clk); bus.cpu_req = 1'b0;
    force dut.hit_cnt_q = start;
    #1 release dut.hit_cnt_q;
    #1;
    n_tests++;
    if (hit_cnt !== start) begin
      n_fail++; $display("FAIL t5_preload: got %h want %h", hit_cnt, start);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); bus.cpu_addr = 32'h100; bus.cpu_req = 1'b1; #2;
      e = 64'(start) + 64'(k);
      if (e > 64'(CNT_MAX)) e = 64'(CNT_MAX);
      n_tests++;
      if (hit_cnt !== CNT_W'(e) || bus.cpu_instr_valid !== 1'b1) begin
        n_fail++; $display("FAIL t5_sat_%0d: got cnt=%h valid=%b want cnt=%h valid=1",
          k, hit_cnt, bus.cpu_instr_valid, CNT_W'(e));
      end
    end
    @(negedge clk); bus.cpu_req = 1'b0; #2;
    n_tests++;
    if (hit_cnt !== CNT_MAX) begin
      n_fail++; $display("FAIL t5_final: got %h want %h", hit_cnt, CNT_MAX);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_pc_change();
    test_reset_mid_miss();
    test_random();
    test_hit_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
